// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared core constants and fetch-buffer entry type
package fetch_unit_pkg;
   localparam int              XLEN         = 32;
   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fb_entry_t;
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/grant and in-order response channel
interface fetch_unit_if;
   import fetch_unit_pkg::*;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry {pc, instr} buffer between imem responses and decode
module fetch_fifo
   import fetch_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  logic      flush,
   input  fb_entry_t wdata,
   output fb_entry_t rdata,
   output logic      full,
   output logic      empty
);
   fb_entry_t  mem [2];
   logic       wp, rp, do_push, do_pop;
   logic [1:0] cnt;
   assign full    = cnt == 2'd2;
   assign empty   = cnt == 2'd0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rp];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else if (flush) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         wp  <= wp ^ do_push;
         rp  <= rp ^ do_pop;
         cnt <= cnt + 2'(do_push) - 2'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wp] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a two-entry buffer and branch redirect;
// responses still in flight at a redirect are counted out by a drop counter.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              FB_DEPTH = 2
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_en,
   input  logic            taken,
   input  logic [XLEN-1:0] target,
   fetch_unit_if.master    imem,
   output logic            de_valid,
   output logic [XLEN-1:0] de_pc,
   output logic [XLEN-1:0] de_instr
);
   logic [XLEN-1:0] fpc, rpc;
   logic [1:0]      outs, outs_nxt, drop, buffered;
   logic            fire, resp, push, pop, full, empty;
   fb_entry_t       head, wdata;
   assign buffered       = full ? 2'd2 : {1'b0, !empty};
   assign imem.imem_addr = fpc;
   assign imem.imem_req  = rst_n && !taken && (int'(outs) + int'(buffered) < FB_DEPTH);
   assign fire           = imem.imem_req && imem.imem_gnt;
   assign resp           = imem.imem_rvalid && outs != 2'd0;
   assign outs_nxt       = outs + 2'(fire) - 2'(resp);
   // a response landing in the redirect cycle belongs to the old stream
   assign push           = resp && drop == 2'd0 && !taken;
   assign pop            = de_valid && if_en && !taken;
   assign wdata          = '{pc: rpc, instr: imem.imem_rdata};
   assign de_valid       = !empty;
   assign de_pc          = empty ? '0 : head.pc;
   assign de_instr       = empty ? NOP_INSTR : head.instr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fpc  <= RESET_PC;
         rpc  <= RESET_PC;
         outs <= 2'd0;
         drop <= 2'd0;
      end else begin
         outs <= outs_nxt;
         fpc  <= taken ? align_pc(target) : fire ? fpc + 32'd4 : fpc;
         rpc  <= taken ? align_pc(target) : push ? rpc + 32'd4 : rpc;
         drop <= taken ? outs_nxt : (resp && drop != 2'd0) ? drop - 2'd1 : drop;
      end
   fetch_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (taken),
      .wdata (wdata),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch bench with a queue-based reference of memory and decode
module tb_fetch_unit;
   import fetch_unit_pkg::*;
   typedef struct { logic [31:0] addr; bit stale; } req_t;
   logic        clk = 0, rst_n = 0, if_en = 0, taken = 0;
   logic [31:0] target = 0;
   logic        de_valid;
   logic [31:0] de_pc, de_instr;
   int          checks = 0, failures = 0;
   bit          gnt_rand = 0, rv_rand = 0, rv_hold = 0;
   req_t        q[$];
   logic [31:0] mq[$];
   logic [31:0] exp_next;

   fetch_unit_if bus();
   fetch_unit #(.RESET_PC(32'h0), .FB_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .if_en(if_en), .taken(taken), .target(target),
      .imem(bus.master), .de_valid(de_valid), .de_pc(de_pc), .de_instr(de_instr)
   );

   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // reference: q = memory requests in flight (stale after a redirect), mq = pcs decode should see
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mq.delete();
      end else begin
         if (if_en && !taken && mq.size() > 0) void'(mq.pop_front());
         if (bus.imem_rvalid && q.size() > 0) begin
            if (!taken && !q[0].stale) mq.push_back(q[0].addr);
            void'(q.pop_front());
         end
         if (taken) begin
            mq.delete();
            foreach (q[i]) q[i].stale = 1;
         end
         if (bus.imem_req && bus.imem_gnt) q.push_back('{bus.imem_addr, 1'b0});
      end
   end

   always @(posedge clk) begin
      #1;
      bus.imem_gnt    = gnt_rand ? 1'($urandom) : 1'b1;
      bus.imem_rvalid = !rv_hold && q.size() > 0 && (rv_rand ? 1'($urandom) : 1'b1);
      bus.imem_rdata  = q.size() > 0 ? word(q[0].addr) : $urandom;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) tick();
      #1;
      checks++; if (de_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", de_valid); end
      checks++; if (de_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", de_pc); end
      checks++; if (de_instr !== NOP_INSTR) begin failures++; $display("FAIL reset_instr: got %h want %h", de_instr, NOP_INSTR); end
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
      rst_n = 1;
      #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL release_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
      tick();
   endtask

   task automatic test_stream();
      logic [31:0] seen[$];
      int first = -1;
      if_en = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (de_valid !== (mq.size() > 0) || (mq.size() > 0 && (de_pc !== mq[0] || de_instr !== word(mq[0]))) || (mq.size() == 0 && de_instr !== NOP_INSTR)) begin
            failures++; $display("FAIL stream_out: got v=%b pc=%h instr=%h want n=%0d", de_valid, de_pc, de_instr, mq.size());
         end
         checks++;
         if (bus.imem_req !== (q.size() + mq.size() < 2)) begin failures++; $display("FAIL stream_req: got %b want %b", bus.imem_req, q.size() + mq.size() < 2); end
         if (de_valid && first < 0) first = i;
         if (de_valid) seen.push_back(de_pc);
         tick();
      end
      checks++; if (first < 1) begin failures++; $display("FAIL first_valid: got cycle %0d want >=1 after first gnt", first); end
      checks++;
      if (seen.size() < 3 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8) begin
         failures++; $display("FAIL stream_seq: got n=%0d first=%h,%h,%h want 0,4,8", seen.size(), seen[0], seen[1], seen[2]);
      end
   endtask

   task automatic test_stall();
      logic [31:0] hold;
      int n, cnt = 0;
      if_en = 0;
      for (n = 0; n < 12; n++) begin
         #1;
         if (mq.size() > 0 && q.size() + mq.size() == 2) break;
         tick();
      end
      checks++; if (n >= 12) begin failures++; $display("FAIL stall_fill: got occupancy %0d want 2", q.size() + mq.size()); end
      hold = mq[0];
      tick();
      repeat (5) begin
         #1;
         checks++; if (de_valid !== 1'b1 || de_pc !== hold || de_instr !== word(hold)) begin failures++; $display("FAIL stall_hold: got v=%b pc=%h instr=%h want pc=%h", de_valid, de_pc, de_instr, hold); end
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b want 0", bus.imem_req); end
         tick();
      end
      if_en = 1;
      exp_next = hold;
      repeat (10) begin
         #1;
         if (de_valid) begin
            checks++; if (de_pc !== exp_next || de_instr !== word(exp_next)) begin failures++; $display("FAIL stall_release: got pc=%h want %h", de_pc, exp_next); end
            exp_next += 4; cnt++;
         end
         tick();
      end
      checks++; if (cnt < 3) begin failures++; $display("FAIL stall_progress: got %0d instrs want >=3", cnt); end
   endtask

   task automatic test_redirect();
      int n;
      bit seen_req = 0;
      if_en = 1;
      #1;
      rv_hold = 1;
      tick();
      for (n = 0; n < 10; n++) begin
         #1;
         if (q.size() == 2) break;
         tick();
      end
      checks++; if (n >= 10) begin failures++; $display("FAIL redir_outstanding: got %0d want 2", q.size()); end
      taken = 1; target = 32'h0000_0102; rv_hold = 0;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL redir_req: got %b want 0", bus.imem_req); end
      tick();
      taken = 0;
      for (n = 0; n < 20; n++) begin
         #1;
         if (!seen_req && bus.imem_req) begin
            seen_req = 1;
            checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr: got %h want 00000100", bus.imem_addr); end
         end
         if (de_valid) break;
         tick();
      end
      checks++; if (!de_valid || de_pc !== 32'h100 || de_instr !== word(32'h100)) begin failures++; $display("FAIL redir_first: got v=%b pc=%h instr=%h want pc=00000100", de_valid, de_pc, de_instr); end
      tick();
   endtask

   task automatic test_taken_gnt_pop();
      int n, cnt = 0;
      logic [31:0] tgt;
      if_en = 1;
      for (n = 0; n < 10; n++) begin
         #1;
         if (de_valid && q.size() > 0) break;
         tick();
      end
      checks++; if (n >= 10) begin failures++; $display("FAIL tgp_setup: got v=%b out=%0d want busy pipe", de_valid, q.size()); end
      tgt = $urandom;
      taken = 1; target = tgt;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL tgp_req: got %b want 0", bus.imem_req); end
      tick();
      taken = 0;
      exp_next = tgt & ~32'd3;
      repeat (15) begin
         #1;
         if (de_valid) begin
            checks++; if (de_pc !== exp_next || de_instr !== word(exp_next)) begin failures++; $display("FAIL tgp_seq: got pc=%h want %h", de_pc, exp_next); end
            exp_next += 4; cnt++;
         end
         tick();
      end
      checks++; if (cnt < 2) begin failures++; $display("FAIL tgp_progress: got %0d want >=2", cnt); end
   endtask

   task automatic test_wrap();
      bit armed = 0, wrapped = 0;
      taken = 1; target = 32'hFFFF_FFF8;
      #1;
      tick();
      taken = 0;
      exp_next = 32'hFFFF_FFF8;
      repeat (20) begin
         #1;
         if (armed && !wrapped) begin
            wrapped = 1;
            checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr); end
         end
         if (bus.imem_req && bus.imem_gnt && bus.imem_addr == 32'hFFFF_FFFC) armed = 1;
         if (de_valid) begin
            checks++; if (de_pc !== exp_next || de_instr !== word(exp_next)) begin failures++; $display("FAIL wrap_seq: got pc=%h want %h", de_pc, exp_next); end
            exp_next += 4;
         end
         tick();
      end
      checks++; if (!wrapped || exp_next < 32'd4 || exp_next > 32'h40) begin failures++; $display("FAIL wrap_progress: got wrapped=%b next=%h", wrapped, exp_next); end
   endtask

   task automatic test_random();
      gnt_rand = 1; rv_rand = 1;
      for (int i = 0; i < 400; i++) begin
         if_en  = 1'($urandom);
         taken  = i == 0 || $urandom_range(15) == 0;
         target = $urandom;
         #1;
         checks++;
         if (de_valid !== (mq.size() > 0) || (mq.size() > 0 && (de_pc !== mq[0] || de_instr !== word(mq[0]))) || (mq.size() == 0 && de_instr !== NOP_INSTR)) begin
            failures++; $display("FAIL rand_out: cyc %0d got v=%b pc=%h instr=%h want n=%0d", i, de_valid, de_pc, de_instr, mq.size());
         end
         checks++;
         if (bus.imem_req !== (q.size() + mq.size() < 2 && !taken)) begin failures++; $display("FAIL rand_req: cyc %0d got %b", i, bus.imem_req); end
         if (taken) exp_next = target & ~32'd3;
         else if (if_en && de_valid) begin
            checks++; if (de_pc !== exp_next) begin failures++; $display("FAIL rand_order: cyc %0d got pc=%h want %h", i, de_pc, exp_next); end
            exp_next += 4;
         end
         tick();
      end
      taken = 0; if_en = 1; gnt_rand = 0; rv_rand = 0;
   endtask

   task automatic test_reset_mid();
      int n, cnt = 0;
      if_en = 1;
      for (n = 0; n < 20; n++) begin
         #1;
         if (q.size() == 1) break;
         tick();
      end
      checks++; if (n >= 20) begin failures++; $display("FAIL mid_setup: got out=%0d want 1", q.size()); end
      rst_n = 0;
      #1;
      checks++; if (de_valid !== 1'b0 || de_pc !== 32'h0 || de_instr !== NOP_INSTR) begin failures++; $display("FAIL mid_out: got v=%b pc=%h instr=%h want 0/0/%h", de_valid, de_pc, de_instr, NOP_INSTR); end
      checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mid_req: got req=%b addr=%h want 0/0", bus.imem_req, bus.imem_addr); end
      tick();
      tick();
      rst_n = 1;
      #1;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mid_restart: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
      tick();
      exp_next = 32'h0;
      repeat (12) begin
         #1;
         if (de_valid) begin
            checks++; if (de_pc !== exp_next || de_instr !== word(exp_next)) begin failures++; $display("FAIL mid_seq: got pc=%h want %h", de_pc, exp_next); end
            exp_next += 4; cnt++;
         end
         tick();
      end
      checks++; if (cnt < 2) begin failures++; $display("FAIL mid_progress: got %0d want >=2", cnt); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_taken_gnt_pop();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
